// File: rtl/wb_arbiter_pkg.sv
// Shared EXE/WB definitions for the writeback arbiter.
// Pipe IDs double as fixed arbitration priority.
package wb_arbiter_pkg;

  localparam int NUM_EXE_PIPES    = 4;
  localparam int EXE_PIPE_ID_ALU  = 0;
  localparam int EXE_PIPE_ID_LSU  = 1;
  localparam int EXE_PIPE_ID_MUL  = 2;
  localparam int EXE_PIPE_ID_DIV  = 3;

  localparam int REG_WIDTH        = 32;
  localparam int NUM_REGS         = 32;
  localparam int REG_ADDR_W       = 5;

  localparam int WB_STARVE_LIMIT  = 4;
  localparam int WB_AGE_W         = 3;

  typedef struct packed {
    logic                  wr_en;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_WIDTH-1:0]  wr_data;
  } wb_ix_inf_t;

  typedef struct packed {
    logic                  wr;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_WIDTH-1:0]  data;
  } wb_req_t;

  function automatic logic is_real_write(
    input wb_req_t r
  );
    return r.wr && (r.rd != '0);
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Exe-pipe to IX writeback bundle.
// master = exe pipes, slave = arbiter.
interface wb_arbiter_if;
  import wb_arbiter_pkg::*;

  logic [NUM_EXE_PIPES-1:0]                 req_valid;
  logic [NUM_EXE_PIPES-1:0]                 req_wr;
  logic [NUM_EXE_PIPES-1:0][REG_ADDR_W-1:0] req_rd;
  logic [NUM_EXE_PIPES-1:0][REG_WIDTH-1:0]  req_data;
  logic [NUM_EXE_PIPES-1:0]                 req_ready;
  wb_ix_inf_t                               wb_out;
  logic [NUM_EXE_PIPES-1:0]                 grant;
  logic [NUM_REGS-1:0]                      pending_rd;

  modport master (
    output req_valid, req_wr, req_rd, req_data,
    input  req_ready, wb_out, grant, pending_rd
  );

  modport slave (
    input  req_valid, req_wr, req_rd, req_data,
    output req_ready, wb_out, grant, pending_rd
  );

endinterface

// File: rtl/wb_arbiter_hold.sv
// One-entry holding buffer with starvation age.
// Incoming request bypasses the buffer when empty.
module wb_hold_buffer
  import wb_arbiter_pkg::*;
#(
  parameter int AGE_W = WB_AGE_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_take,
  input  wb_req_t               in_req,
  input  logic                  win,
  output logic                  cand,
  output wb_req_t               cand_req,
  output logic [AGE_W-1:0]      age,
  output logic                  full,
  output logic [REG_ADDR_W-1:0] buf_rd,
  output logic                  ready
);

  wb_req_t          buf_q;
  logic             full_q;
  logic [AGE_W-1:0] age_q;

  assign cand     = full_q | in_take;
  assign cand_req = full_q ? buf_q : in_req;
  assign age      = age_q;
  assign full     = full_q;
  assign buf_rd   = buf_q.rd;
  assign ready    = !full_q;

  // Drain on a win; capture an incoming loser.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      buf_q  <= '0;
    end else if (full_q) begin
      if (win) full_q <= 1'b0;
    end else if (in_take && !win) begin
      full_q <= 1'b1;
      buf_q  <= in_req;
    end
  end

  // Count consecutive lost arbitrations, saturating.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      age_q <= '0;
    end else if (cand && !win) begin
      if (age_q != {AGE_W{1'b1}}) age_q <= age_q + 1'b1;
    end else begin
      age_q <= '0;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback port arbiter: ALU > LSU > MUL > DIV,
// with age-based promotion of starved pipes.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_PIPES    = NUM_EXE_PIPES,
  parameter int STARVE_LIMIT = WB_STARVE_LIMIT,
  parameter int AGE_W        = WB_AGE_W
) (
  input logic        clk,
  input logic        rst_n,
  wb_arbiter_if.slave bus
);

  localparam logic [AGE_W-1:0] LIMIT = AGE_W'(STARVE_LIMIT);

  logic [NUM_PIPES-1:0]  take;
  logic [NUM_PIPES-1:0]  cand;
  logic [NUM_PIPES-1:0]  win;
  logic [NUM_PIPES-1:0]  full;
  logic [NUM_PIPES-1:0]  ready;
  wb_req_t               in_req   [NUM_PIPES];
  wb_req_t               cand_req [NUM_PIPES];
  logic [AGE_W-1:0]      age      [NUM_PIPES];
  logic [REG_ADDR_W-1:0] buf_rd   [NUM_PIPES];

  wb_req_t               win_req;
  logic                  found;
  wb_ix_inf_t            wb_q;
  logic [NUM_PIPES-1:0]  grant_q;
  logic [NUM_REGS-1:0]   pend;

  for (genvar p = 0; p < NUM_PIPES; p++) begin : g_pipe
    assign in_req[p] = '{
      wr:   bus.req_wr[p],
      rd:   bus.req_rd[p],
      data: bus.req_data[p]
    };
    assign take[p] = bus.req_valid[p] & ready[p]
                   & is_real_write(in_req[p]);

    wb_hold_buffer #(.AGE_W(AGE_W)) u_hold (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_take  (take[p]),
      .in_req   (in_req[p]),
      .win      (win[p]),
      .cand     (cand[p]),
      .cand_req (cand_req[p]),
      .age      (age[p]),
      .full     (full[p]),
      .buf_rd   (buf_rd[p]),
      .ready    (ready[p])
    );
  end

  // Starved candidates first, then plain fixed priority.
  always_comb begin
    win     = '0;
    found   = 1'b0;
    win_req = '0;
    for (int p = 0; p < NUM_PIPES; p++) begin
      if (!found && cand[p] && age[p] >= LIMIT) begin
        win[p]  = 1'b1;
        found   = 1'b1;
        win_req = cand_req[p];
      end
    end
    for (int p = 0; p < NUM_PIPES; p++) begin
      if (!found && cand[p]) begin
        win[p]  = 1'b1;
        found   = 1'b1;
        win_req = cand_req[p];
      end
    end
  end

  // Register the winning write; rd/data hold when idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_q    <= '0;
      grant_q <= '0;
    end else if (found) begin
      wb_q    <= '{
        wr_en:   win_req.wr,
        rd:      win_req.rd,
        wr_data: win_req.data
      };
      grant_q <= win;
    end else begin
      wb_q.wr_en <= 1'b0;
      grant_q    <= '0;
    end
  end

  // Destinations currently parked in a buffer.
  always_comb begin
    pend = '0;
    for (int p = 0; p < NUM_PIPES; p++) begin
      if (full[p]) pend[buf_rd[p]] = 1'b1;
    end
  end

  assign bus.req_ready  = ready;
  assign bus.wb_out     = wb_q;
  assign bus.grant      = grant_q;
  assign bus.pending_rd = pend;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: stimulus pushes
// model expectations, a monitor pops and compares.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  typedef logic [3:0]       vec_t;
  typedef logic [3:0][4:0]  rdv_t;
  typedef logic [3:0][31:0] datv_t;

  typedef struct {
    logic        wr_en;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [3:0]  grant;
    logic [3:0]  ready;
    logic [31:0] pend;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_arbiter_if bus();

  wb_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t        exp_q[$];
  logic [31:0] inflight[int];
  int          n_checks = 0;
  int          n_fail   = 0;

  // Reference model: one parked result per pipe plus
  // a count of consecutive lost arbitrations.
  logic        m_held [4];
  logic [4:0]  m_rd   [4];
  logic [31:0] m_data [4];
  int          m_wait [4];
  logic [4:0]  m_last_rd;
  logic [31:0] m_last_data;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, req);
    end
  endtask

  function automatic rdv_t mk_rd(input int a, b, c, d);
    rdv_t r;
    r[0] = 5'(a); r[1] = 5'(b);
    r[2] = 5'(c); r[3] = 5'(d);
    return r;
  endfunction

  function automatic datv_t mk_d(input logic [31:0] a, b, c, d);
    datv_t r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    return r;
  endfunction

  task automatic do_reset();
    exp_t e;
    @(negedge clk);
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_wr    = '0;
    bus.req_rd    = '0;
    bus.req_data  = '0;
    for (int p = 0; p < 4; p++) begin
      m_held[p] = 1'b0;
      m_rd[p]   = '0;
      m_data[p] = '0;
      m_wait[p] = 0;
    end
    m_last_rd   = '0;
    m_last_data = '0;
    inflight.delete();
    e = '{1'b0, 5'd0, 32'd0, 4'd0, 4'hf, 32'd0};
    exp_q.push_back(e);
  endtask

  task automatic cycle(input vec_t v, input vec_t w,
                       input rdv_t rd, input datv_t d);
    exp_t        e;
    vec_t        ve;
    logic        cv  [4];
    logic        nw  [4];
    logic [4:0]  crd [4];
    logic [31:0] cd  [4];
    int          win;
    @(negedge clk);
    rst_n = 1'b1;
    for (int p = 0; p < 4; p++) ve[p] = v[p] && !m_held[p];
    bus.req_valid = ve;
    bus.req_wr    = w;
    bus.req_rd    = rd;
    bus.req_data  = d;
    for (int p = 0; p < 4; p++) begin
      cv[p] = 1'b0; nw[p] = 1'b0;
      crd[p] = '0;  cd[p] = '0;
      if (ve[p]) chk("valid_while_ready_low",
                     64'(bus.req_ready[p]), 1);
      if (m_held[p]) begin
        cv[p] = 1'b1; crd[p] = m_rd[p]; cd[p] = m_data[p];
      end else if (ve[p] && w[p] && rd[p] != 0) begin
        chk("rd_unique", 64'(inflight.exists(int'(rd[p]))), 0);
        inflight[int'(rd[p])] = d[p];
        cv[p] = 1'b1; nw[p] = 1'b1;
        crd[p] = rd[p]; cd[p] = d[p];
      end
    end
    win = -1;
    for (int p = 0; p < 4; p++)
      if (win < 0 && cv[p] && m_wait[p] >= WB_STARVE_LIMIT)
        win = p;
    for (int p = 0; p < 4; p++)
      if (win < 0 && cv[p]) win = p;
    e.wr_en = 1'b0;
    e.grant = '0;
    if (win >= 0) begin
      e.wr_en     = 1'b1;
      e.grant     = 4'(1 << win);
      m_last_rd   = crd[win];
      m_last_data = cd[win];
    end
    e.rd   = m_last_rd;
    e.data = m_last_data;
    for (int p = 0; p < 4; p++) begin
      if (cv[p] && p != win) begin
        if (nw[p]) begin
          m_held[p] = 1'b1; m_rd[p] = crd[p]; m_data[p] = cd[p];
        end
        m_wait[p] = (m_wait[p] < 7) ? m_wait[p] + 1 : 7;
      end else begin
        m_wait[p] = 0;
        if (p == win) m_held[p] = 1'b0;
      end
    end
    e.pend = '0;
    for (int p = 0; p < 4; p++) begin
      e.ready[p] = !m_held[p];
      if (m_held[p]) e.pend[m_rd[p]] = 1'b1;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cycle('0, '0, mk_rd(0, 0, 0, 0), mk_d(0, 0, 0, 0));
  endtask

  // Monitor: one expectation per clock once traffic starts.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wr_en", 64'(bus.wb_out.wr_en), 64'(e.wr_en));
        chk("wb_rd", 64'(bus.wb_out.rd), 64'(e.rd));
        chk("wb_data", 64'(bus.wb_out.wr_data), 64'(e.data));
        chk("grant", 64'(bus.grant), 64'(e.grant));
        chk("req_ready", 64'(bus.req_ready), 64'(e.ready));
        chk("pending_rd", 64'(bus.pending_rd), 64'(e.pend));
        if (bus.wb_out.wr_en === 1'b1) begin
          chk("wb_rd_known",
              64'(inflight.exists(int'(bus.wb_out.rd))), 1);
          if (inflight.exists(int'(bus.wb_out.rd))) begin
            chk("wb_data_once", 64'(bus.wb_out.wr_data),
                64'(inflight[int'(bus.wb_out.rd)]));
            inflight.delete(int'(bus.wb_out.rd));
          end
        end
      end
    end
  end

  initial begin : stim
    vec_t        v, w;
    rdv_t        r;
    datv_t       d;
    logic [31:0] used;
    int          pick;
    bus.req_valid = '0;
    bus.req_wr    = '0;
    bus.req_rd    = '0;
    bus.req_data  = '0;
    do_reset();

    // Reset with LSU/MUL parked.
    cycle(4'b0111, 4'b0111, mk_rd(1, 2, 3, 0),
          mk_d(32'h11, 32'h22, 32'h33, 0));
    do_reset();

    // Single pipe stream, then null writes.
    cycle(4'b0100, 4'b0100, mk_rd(0, 0, 5, 0), mk_d(0, 0, 32'hA, 0));
    cycle(4'b0100, 4'b0100, mk_rd(0, 0, 6, 0), mk_d(0, 0, 32'hB, 0));
    cycle(4'b0100, 4'b0100, mk_rd(0, 0, 7, 0), mk_d(0, 0, 32'hC, 0));
    cycle(4'b0100, 4'b0100, mk_rd(0, 0, 0, 0), mk_d(0, 0, 32'hD, 0));
    cycle(4'b0100, 4'b0000, mk_rd(0, 0, 8, 0), mk_d(0, 0, 32'hE, 0));
    idle(2);

    // ALU vs DIV collision.
    cycle(4'b1001, 4'b1001, mk_rd(1, 0, 0, 2),
          mk_d(32'h100, 0, 0, 32'h200));
    idle(3);

    // DIV starved by a continuous ALU stream.
    for (int i = 0; i < 10; i++)
      cycle({i == 0, 2'b00, 1'b1}, 4'b1111,
            mk_rd(10 + i, 0, 0, 3), mk_d(32'h1000 + i, 0, 0, 32'hD1));
    idle(4);

    // Four-way collision.
    cycle(4'b1111, 4'b1111, mk_rd(20, 21, 22, 23),
          mk_d(32'hA0, 32'hA1, 32'hA2, 32'hA3));
    idle(5);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      used = '0;
      for (int p = 0; p < 4; p++) begin
        v[p] = ($urandom_range(0, 99) < 55);
        w[p] = ($urandom_range(0, 9) != 0);
        d[p] = $urandom;
        r[p] = '0;
        if ($urandom_range(0, 19) != 0) begin
          pick = 0;
          for (int t = 0; t < 64 && pick == 0; t++) begin
            pick = $urandom_range(1, 31);
            if (inflight.exists(pick) || used[pick]) pick = 0;
          end
          if (pick == 0) v[p] = 1'b0;
          r[p] = 5'(pick);
          used[pick] = 1'b1;
        end
      end
      cycle(v, w, r, d);
    end
    idle(8);

    @(posedge clk);
    #3;
    chk("queue_drained", 64'(exp_q.size()), 0);
    chk("all_writes_seen", 64'(inflight.num()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
